// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, one-cycle fetch-to-decode latency, stall and redirect handling.
// Optional build macro HALT_AT_ZERO_EN stops fetching when the PC reaches address 0.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        active
);

  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic        r_active;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic        w_halt;

  assign w_target = {redirect_target[31:2], 2'b00};

  // A fresh redirect overrides one left pending from a stall.
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (redirect_valid)
      w_pc_next = w_target;
    else if (r_pend_valid)
      w_pc_next = r_pend_target;
  end

  // Decoded from the PC register only; instr_address stays a plain flop output.
`ifdef HALT_AT_ZERO_EN
  assign w_halt = (r_pc == 32'h0);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_if_instr    <= 32'h0;
      r_if_pc       <= 32'h0;
      r_if_valid    <= 1'b0;
      r_active      <= 1'b1;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
    end else if (!r_active) begin
      r_if_valid <= 1'b0;
    end else if (w_halt) begin
      r_active     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (stall) begin
      if (redirect_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
      end
    end else begin
      r_if_instr   <= instr_readdata;
      r_if_pc      <= r_pc;
      r_if_valid   <= 1'b1;
      r_pc         <= w_pc_next;
      r_pend_valid <= 1'b0;
    end
  end

  assign instr_address = r_pc;
  assign if_instr      = r_if_instr;
  assign if_pc         = r_if_pc;
  assign if_valid      = r_if_valid;
  assign active        = r_active;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random stall/redirect/reset traffic.
// Define HALT_AT_ZERO_EN for both bench and RTL to check the halting build.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;
`ifdef HALT_AT_ZERO_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        active;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .active         (active)
  );

  // Fake instruction memory: every address yields a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  assign instr_readdata = mem_word(instr_address);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the PC, the last delivered (pc, word) pair, and the
  // most recent un-applied redirect target.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_valid;
  bit          m_active;
  logic [31:0] pend_q[$];

  task automatic model_step(input bit rs, input bit st, input bit rv,
                            input logic [31:0] rt);
    logic [31:0] nxt;
    if (rs) begin
      m_pc = RV; m_instr = 0; m_ipc = 0;
      m_valid = 0; m_active = 1;
      pend_q.delete();
    end else if (!m_active) begin
      m_valid = 0;
    end else if (HALT && m_pc == 0) begin
      m_active = 0; m_valid = 0;
      pend_q.delete();
    end else if (st) begin
      if (rv) begin
        pend_q.delete();
        pend_q.push_back(rt & ~32'd3);
      end
    end else begin
      m_instr = mem_word(m_pc);
      m_ipc   = m_pc;
      m_valid = 1;
      nxt = m_pc + 32'd4;
      if (pend_q.size() > 0) nxt = pend_q[0];
      if (rv) nxt = rt & ~32'd3;
      m_pc = nxt;
      pend_q.delete();
    end
  endtask

  task automatic check_all();
    check("addr", instr_address, m_pc);
    check("valid", {31'b0, if_valid}, {31'b0, m_valid});
    check("active", {31'b0, active}, {31'b0, m_active});
    check("if_pc", if_pc, m_ipc);
    check("if_instr", if_instr, m_instr);
  endtask

  task automatic cycle(input bit rs, input bit st, input bit rv,
                       input logic [31:0] rt);
    reset = rs; stall = st;
    redirect_valid = rv; redirect_target = rt;
    @(posedge clk);
    model_step(rs, st, rv, rt);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; stall = 0;
    redirect_valid = 0; redirect_target = 0;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h1234);
    check("rst_addr", instr_address, RV);
    check("rst_valid", {31'b0, if_valid}, 32'd0);

    // Free running: address steps by 4, if_pc lags one cycle.
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0);
      check("run_addr", instr_address, RV + 32'(4 * i));
      check("run_ifpc", if_pc, RV + 32'(4 * (i - 1)));
    end

    // Redirect with delay slot.
    cycle(0, 0, 1, 32'hBFC00100);
    check("ds_ifpc", if_pc, 32'hBFC00010);
    check("ds_addr", instr_address, 32'hBFC00100);
    cycle(0, 0, 0, 0);
    check("tgt_ifpc", if_pc, 32'hBFC00100);

    // Redirect during a 3-cycle stall.
    cycle(0, 1, 1, 32'hBFC00200);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("stall_addr", instr_address, 32'hBFC00104);
    check("stall_ifpc", if_pc, 32'hBFC00100);
    cycle(0, 0, 0, 0);
    check("rel_addr", instr_address, 32'hBFC00200);

    // Latest of two pending redirects wins.
    cycle(0, 1, 1, 32'h000000A0);
    cycle(0, 1, 1, 32'h000000B2);
    cycle(0, 0, 0, 0);
    check("latest_addr", instr_address, 32'h000000B0);

    // Reset during stall with a pending redirect.
    cycle(0, 1, 1, 32'h00000300);
    cycle(1, 1, 0, 0);
    check("rst2_addr", instr_address, RV);
    check("rst2_active", {31'b0, active}, 32'd1);
    cycle(0, 0, 0, 0);
    check("rst2_ifpc", if_pc, RV);

    // Redirect to address 0 (low bits ignored).
    cycle(0, 0, 1, 32'h00000003);
    check("zero_addr", instr_address, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h00000040);
    if (HALT) begin
      check("halt_active", {31'b0, active}, 32'd0);
      check("halt_pc", instr_address, 32'h0);
    end else begin
      check("zero_ifpc", if_pc, 32'h00000004);
      check("zero_active", {31'b0, active}, 32'd1);
    end
    cycle(1, 0, 0, 0);

    // Wrap from the top of the address space.
    cycle(0, 0, 1, 32'hFFFFFFFC);
    cycle(0, 0, 0, 0);
    check("wrap_addr", instr_address, 32'h0);
    check("wrap_ifpc", if_pc, 32'hFFFFFFFC);
    cycle(1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit rs, st, rv;
      logic [31:0] rt;
      rs = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      rt = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7))
                                        : $urandom;
      cycle(rs, st, rv, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, first PC fetched after reset.
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  in  1  decode cannot accept; fetch holds.
REQ-005 SHALL have port redirect_valid  in  1  branch/jump taken, one-cycle pulse from decode.
REQ-006 SHALL have port redirect_target  in  32  byte address of branch/jump target.
REQ-007 SHALL have port instr_address  out  32  byte PC presented to instruction memory.
REQ-008 SHALL have port instr_readdata  in  32  instruction word, combinationally valid in the same cycle as instr_address.
REQ-009 SHALL have port if_valid  out  1  if_instr/if_pc hold a real instruction.
REQ-010 SHALL have port if_instr  out  32  registered instruction to decode.
REQ-011 SHALL have port if_pc  out  32  byte address of if_instr.
REQ-012 SHALL have port active  out  1  CPU running; low once halted.

Function
REQ-013 SHALL hold the PC register; instr_address = PC at all times.
REQ-014 SHALL, each cycle with stall=0 and active=1, capture instr_readdata into if_instr and PC into if_pc, set if_valid=1, and advance the PC; fetch-to-decode latency is one cycle.
REQ-015 SHALL, when stall=1, hold PC, if_instr, if_pc and if_valid unchanged.
REQ-016 SHALL advance the PC by 4, modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000, no flag).
REQ-017 SHALL, on redirect_valid=1 with stall=0, load PC with {redirect_target[31:2],2'b00} instead of PC+4, while the instruction fetched this cycle (delay slot) is still captured normally.
REQ-018 SHALL, on redirect_valid=1 with stall=1, store the target in a pending register, and SHALL apply it as in REQ-017 on the first cycle with stall=0.
REQ-019 SHALL, when a new redirect arrives while one is pending, overwrite the pending target (latest wins).
REQ-020 SHALL ignore redirect_target[1:0]; the PC is always word-aligned.
REQ-021 SHALL, when active=0, hold the PC and drive if_valid=0; redirect and stall are ignored.

Reset
REQ-022 SHALL, with reset=1 at a clock edge, set PC=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, active=1, and clear the pending redirect.
REQ-023 SHALL give reset priority over stall, redirect_valid and halt in the same cycle.
REQ-024 SHALL, when reset is asserted mid-operation or mid-stall, discard in-flight and pending state; the first fetch after reset is from RESET_VECTOR.

Configuration
REQ-025 SHALL, with HALT_AT_ZERO_EN defined, treat the PC reaching 32'h00000000 as the halt address: do not fetch it, clear active and if_valid at the next edge, and freeze the PC at 0.
REQ-026 SHALL, without HALT_AT_ZERO_EN, fetch address 0 like any other address and keep active=1 from reset onwards.
REQ-027 SHALL, in both builds, keep the halt check off the instr_address path, so the memory address timing is identical.

Verification
REQ-028 SHALL cover reset then 4 free-running cycles: instr_address = BFC00000, BFC00004, BFC00008, BFC0000C; if_pc lags by one cycle; if_valid=1 from cycle 2.
REQ-029 SHALL cover redirect to 32'hBFC00100 while fetching BFC00010: BFC00010 (delay slot) is delivered, then BFC00100.
REQ-030 SHALL cover redirect to 32'hBFC00200 during a 3-cycle stall: PC and outputs are frozen, and the first fetch after the stall releases is BFC00200.
REQ-031 SHALL cover two redirects (A0, then B0) during one stall: the fetch after release is B0.
REQ-032 SHALL cover, with HALT_AT_ZERO_EN, a redirect to 32'h00000003: active=0 and if_valid=0 one cycle after PC=0, and the PC stays 0; without the macro, address 0 is fetched and active stays 1.
REQ-033 SHALL cover reset asserted during a stall with a redirect pending: the next fetch is RESET_VECTOR, if_valid=0 and active=1.
